clock_gate_scheduler: RTL
=========================

Name: clock_gate_scheduler

Overview:
- Arbitrates stall requests from several agents (host DMA, debug, memory refill) that need the compute clock paused.
- Sequences the active-low CE of the glitchless clock buffer: drain window, gate, hold, resume.
- Runs on the free-running source clock, never on the gated clock, and sits beside the clock buffer at the top of the compute array.

Parameters:
- NUM_REQ, 4: number of stall requesters (range 1..16).
- DRAIN_CYCLES, 2: cycles the clock keeps running after the first request before gating (must be ≥1).
- RESUME_CYCLES, 1: cycles after un-gating during which new requests are not granted (must be ≥1).
- CNT_W, 32: width of the stall-cycle counter (optional feature only).

Ports:
- clock  in  1  free-running source clock; same net as the clock buffer's I.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-agent stall request, level; held until ack or withdrawn.
- ack  out  NUM_REQ  per-agent grant: clock is confirmed gated while high.
- clock_enable_n  out  1  to the clock buffer CE; 0 = clock runs, 1 = clock gated.
- stalled  out  1  high while in the STALL state.
- stall_cycles  out  CNT_W  present only with the optional feature.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high) forces state RUN, clock_enable_n=0, ack=0, stalled=0 and a zero counter.
- Reset asserted mid-stall un-gates the clock on the next source edge.
- States:
  - RUN: clock_enable_n=0. If any req is high, go to DRAIN and load drain_cnt=DRAIN_CYCLES-1.
  - DRAIN: clock still runs. If all req drop, go back to RUN; no gating occurs and no ack is issued. When drain_cnt==0 and any req is high, go to STALL. Otherwise decrement drain_cnt.
  - STALL: clock_enable_n=1 and stalled=1 from the first STALL cycle. ack[i] is registered from (state==STALL && req[i]), so ack rises 1 cycle after entry. A late joiner gets ack 1 cycle after raising req. A requester that drops req loses ack 1 cycle later. When all req are low, go to RESUME.
  - RESUME: clock_enable_n=0 and ack=0 from the first RESUME cycle; resume_cnt is loaded with RESUME_CYCLES-1. When resume_cnt==0, go to DRAIN if any req is high, otherwise go to RUN. Requests arriving during RESUME are held off, not dropped.
- Latency: with DRAIN_CYCLES=D and a first req at cycle t, clock_enable_n rises at t+D+1 and ack at t+D+2.
- A req that drops before ack is legal. An ack is never issued unless clock_enable_n is 1 in that same cycle and was also 1 in the previous cycle.
- Simultaneous events:
  - A req drop and a new req from another agent in the same STALL cycle: remain in STALL.
  - All reqs drop while another req rises during RESUME: the new one is served after the RESUME hold.
- clock_enable_n never toggles more than once per source cycle. No combinational path exists from req to clock_enable_n.

Optional Feature:
- Macro CLOCK_GATE_STALL_COUNTER_EN.
- When defined:
  - stall_cycles counts source cycles with clock_enable_n=1.
  - The counter saturates at all-ones and clears on reset.
  - The count is visible on the port 1 cycle after each gated cycle.
- When undefined: the port and the counter are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package clock_gate_pkg holds:
  - the state enum (RUN, DRAIN, STALL, RESUME);
  - the cycle-count helper constant $clog2(max(DRAIN_CYCLES,RESUME_CYCLES)+1);
  - the CE polarity constant CE_ENABLE=0.
- One sub-module, clock_gate_sat_counter: the saturating counter, instantiated only under the macro.
- The FSM and down-counter stay in the top module.

Test Plan:
1. Reset check: reset high 3 cycles with req=4'b0011 -> clock_enable_n=0, ack=0, stalled=0 throughout. After release with D=2, clock_enable_n=1 at cycle 3 and ack=4'b0011 at cycle 4.
2. Aborted drain: req[0] pulses for 1 cycle with D=2 -> clock_enable_n stays 0, ack stays 0, state returns to RUN.
3. Late joiner and release: req[0] is granted; 5 cycles later req[2] rises -> ack[2] 1 cycle later. req[0] drops -> ack[0] drops 1 cycle later and the clock stays gated. req[2] drops -> clock_enable_n=0 1 cycle later.
4. Request held off in RESUME: with RESUME_CYCLES=3, req[1] rises in the first RESUME cycle -> no ack during RESUME, then DRAIN, then regate. ack[1] arrives D+1 cycles after RESUME ends.
5. Reset mid-stall: reset for 1 cycle during STALL -> clock_enable_n=0 and ack=0 on the next edge. Since req is still high, gating restarts through DRAIN.
6. Counter (macro defined, CNT_W=4): hold a stall for 20 gated cycles -> stall_cycles saturates at 15. It is 0 after reset.

Source files
------------

// File: rtl/clock_gate_pkg.sv
// Shared types and constants for the clock-gate scheduler: FSM state encoding,
// clock-enable polarity and the width helper for the drain/resume down-counter.
package clock_gate_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    STALL  = 2'd2,
    RESUME = 2'd3
  } state_e;

  // The clock buffer CE is active-low: 0 lets the compute clock run.
  localparam logic CE_ENABLE = 1'b0;
  localparam logic CE_GATE   = ~CE_ENABLE;

  // Bits needed to hold max(drain_cycles, resume_cycles) in the shared down-counter.
  function automatic int cnt_width(input int drain_cycles, input int resume_cycles);
    int max_cycles;
    max_cycles = (drain_cycles > resume_cycles) ? drain_cycles : resume_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/clock_gate_scheduler_if.sv
// Requester-side bundle of the clock-gate scheduler. The stall_cycles member
// exists only when CLOCK_GATE_STALL_COUNTER_EN is defined.
interface clock_gate_scheduler_if #(
  parameter int NUM_REQ = 4
`ifdef CLOCK_GATE_STALL_COUNTER_EN
  , parameter int CNT_W = 32
`endif
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic               clock_enable_n;
  logic               stalled;
`ifdef CLOCK_GATE_STALL_COUNTER_EN
  logic [CNT_W-1:0]   stall_cycles;
`endif

  modport master (
    output req,
    input  ack,
    input  clock_enable_n,
    input  stalled
`ifdef CLOCK_GATE_STALL_COUNTER_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  req,
    output ack,
    output clock_enable_n,
    output stalled
`ifdef CLOCK_GATE_STALL_COUNTER_EN
    , output stall_cycles
`endif
  );

endinterface

// File: rtl/clock_gate_sat_counter.sv
// Saturating up-counter of gated source cycles; holds at all-ones, cleared by
// the synchronous active-high reset.
module clock_gate_sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/clock_gate_scheduler.sv
// Stall-request arbiter driving the active-low CE of a glitchless clock buffer
// (RUN -> DRAIN -> STALL -> RESUME). Runs on the free-running source clock.
// Define CLOCK_GATE_STALL_COUNTER_EN to add the saturating stall_cycles counter.
module clock_gate_scheduler
  import clock_gate_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DRAIN_CYCLES  = 2,
  parameter int RESUME_CYCLES = 1
`ifdef CLOCK_GATE_STALL_COUNTER_EN
  , parameter int CNT_W       = 32
`endif
) (
  input logic                   clock,
  input logic                   reset,
  clock_gate_scheduler_if.slave bus
);

  localparam int CW = cnt_width(DRAIN_CYCLES, RESUME_CYCLES);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ce_n_q, ce_n_d;
  logic               stalled_q, stalled_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               any_req;

  assign any_req = |bus.req;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (any_req) begin
          state_d = DRAIN;
          cnt_d   = CW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (!any_req) begin
          state_d = RUN;
        end else if (cnt_q == '0) begin
          state_d = STALL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STALL: begin
        if (!any_req) begin
          state_d = RESUME;
          cnt_d   = CW'(RESUME_CYCLES - 1);
        end
      end
      RESUME: begin
        // Requests raised here are only looked at once the hold expires.
        if (cnt_q == '0) begin
          if (any_req) begin
            state_d = DRAIN;
            cnt_d   = CW'(DRAIN_CYCLES - 1);
          end else begin
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = RUN;
    endcase

    ce_n_d    = (state_d == STALL) ? CE_GATE : CE_ENABLE;
    stalled_d = (state_d == STALL);
    // Grant only from a STALL cycle, so CE was already high a cycle earlier.
    ack_d     = (state_q == STALL) ? bus.req : '0;
  end

  // NOTE: state and outputs are updated with non-blocking assignments, and the
  // reset is synchronous: it is sampled on the source clock edge like any input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      ce_n_q    <= CE_ENABLE;
      stalled_q <= 1'b0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ce_n_q    <= ce_n_d;
      stalled_q <= stalled_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.ack            = ack_q;
  assign bus.clock_enable_n = ce_n_q;
  assign bus.stalled        = stalled_q;

`ifdef CLOCK_GATE_STALL_COUNTER_EN
  clock_gate_sat_counter #(
    .W(CNT_W)
  ) u_stall_counter (
    .clock (clock),
    .reset (reset),
    .inc   (ce_n_q == CE_GATE),
    .count (bus.stall_cycles)
  );
`endif

endmodule
